// File: rtl/jogo_pkg.sv
// jogo_pkg: shared screen geometry, sprite sizes and enemy-shot FSM states
package jogo_pkg;
  localparam int Y_LIMITE = 480;
  localparam int LARGURA_NAVE = 45;
  localparam int ALTURA_NAVE = 20;
  localparam int LARGURA_INIMIGO = 40;
  localparam int ALTURA_INIMIGO = 20;
  typedef enum logic [1:0] {ESPERA, VOANDO, ACERTO, FIM} estado_t;
endpackage

// File: rtl/divisor_tick.sv
// divisor_tick: step divider counting 0..TICK_DIV-1, one-cycle tick at terminal count, frozen by pausa
module divisor_tick #(
  parameter int TICK_DIV = 500000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic pausa,
  output logic tick
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = !pausa && cnt_q == W'(TICK_DIV - 1);
  always_comb cnt_d = pausa ? cnt_q : tick ? '0 : cnt_q + W'(1);
  always_ff @(posedge CLOCK_50) cnt_q <= !reset ? '0 : cnt_d;
endmodule

// File: rtl/tiro_inimigo.sv
// tiro_inimigo: enemy ball launch, downward flight, ship impact detection and lives tracking
module tiro_inimigo
  import jogo_pkg::*;
#(
  parameter int TICK_DIV = 500000,
  parameter int VEL = 3,
  parameter int COOLDOWN = 60,
  parameter int RAIO = 5,
  parameter logic [1:0] VIDAS_INI = 2'd3
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       pausa,
  input  logic       reiniciarJogo,
  input  logic [9:0] x_inimigo,
  input  logic [9:0] y_inimigo,
  input  logic       inimigo_vivo,
  input  logic [9:0] x_nave,
  input  logic [9:0] y_nave,
  output logic [9:0] x_bola_inimiga,
  output logic [9:0] y_bola_inimiga,
  output logic [9:0] raio_bola_inimiga,
  output logic       bola_ativa,
  output logic       acertou_nave,
  output logic [1:0] vidas,
  output logic       fim_de_jogo
);
  localparam int CW = COOLDOWN > 0 ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [CW-1:0] CD_INI = CW'(COOLDOWN);
  estado_t estado_q, estado_d;
  logic [CW-1:0] cd_q, cd_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic [1:0] vidas_q, vidas_d;
  logic [10:0] y_next, y_topo;
  logic tick, hit, sai;
  divisor_tick #(.TICK_DIV(TICK_DIV)) u_div (
    .CLOCK_50(CLOCK_50),
    .reset(reset & ~reiniciarJogo),
    .pausa(pausa),
    .tick(tick)
  );
  assign y_next = {1'b0, y_q} + 11'(VEL);
  assign y_topo = y_next >= 11'(RAIO) ? y_next - 11'(RAIO) : '0;
  assign hit = {1'b0, x_nave} <= {1'b0, x_q} && {1'b0, x_q} < {1'b0, x_nave} + 11'(LARGURA_NAVE)
            && y_next + 11'(RAIO) >= {1'b0, y_nave} && y_topo < {1'b0, y_nave} + 11'(ALTURA_NAVE);
  assign sai = y_topo >= 11'(Y_LIMITE);
  always_comb begin
    estado_d = estado_q;
    cd_d = cd_q;
    x_d = x_q;
    y_d = y_q;
    vidas_d = vidas_q;
    if (estado_q == ESPERA && tick) begin
      if (cd_q != '0) cd_d = cd_q - CW'(1);
      else if (inimigo_vivo) begin
        estado_d = VOANDO;
        x_d = x_inimigo + 10'(LARGURA_INIMIGO / 2);
        y_d = y_inimigo + 10'(ALTURA_INIMIGO);
      end
    end else if (estado_q == VOANDO && tick) begin
      if (hit) begin
        estado_d = ACERTO;
        y_d = y_next[9:0];
      end else if (sai) begin
        estado_d = ESPERA;
        cd_d = CD_INI;
      end else y_d = y_next[9:0];
    end else if (estado_q == ACERTO) begin
      vidas_d = vidas_q - 2'd1;
      estado_d = vidas_q == 2'd1 ? FIM : ESPERA;
      cd_d = CD_INI;
    end
  end
  always_ff @(posedge CLOCK_50) begin
    if (!reset || reiniciarJogo) begin
      estado_q <= ESPERA;
      cd_q <= CD_INI;
      x_q <= '0;
      y_q <= '0;
      vidas_q <= VIDAS_INI;
    end else begin
      estado_q <= estado_d;
      cd_q <= cd_d;
      x_q <= x_d;
      y_q <= y_d;
      vidas_q <= vidas_d;
    end
  end
  assign x_bola_inimiga = x_q;
  assign y_bola_inimiga = y_q;
  assign raio_bola_inimiga = 10'(RAIO);
  assign bola_ativa = estado_q == VOANDO || estado_q == ACERTO;
  assign acertou_nave = estado_q == ACERTO;
  assign vidas = vidas_q;
  assign fim_de_jogo = estado_q == FIM;
endmodule
